// File: rtl/eth_log_arb_pkg.sv
// Shared constants and helpers for the Ethernet log-stream arbiter.
package eth_log_arb_pkg;

    localparam int unsigned MAX_INPUTS = 8;
    localparam int unsigned GRANT_W    = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    // Ceiling log2 for elaboration-time width calculation.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/eth_log_rr_pick.sv
// Combinational round-robin picker: first set req bit after last_grant, wrapping.
module eth_log_rr_pick
    import eth_log_arb_pkg::*;
#(
    parameter int unsigned C_NUM_INPUTS = 4
) (
    input  logic [C_NUM_INPUTS-1:0] req,
    input  logic [GRANT_W-1:0]      last_grant,
    output logic [GRANT_W-1:0]      next_idx,
    output logic                    valid
);

    localparam int unsigned IDX_W = clog2(C_NUM_INPUTS);

    // Scan farthest-to-nearest so the closest requester after last_grant wins.
    always_comb begin
        int unsigned cand;
        next_idx = '0;
        valid    = 1'b0;
        cand     = 0;
        for (int unsigned off = C_NUM_INPUTS; off > 0; off--) begin
            cand = 32'(last_grant) + off;
            if (cand >= C_NUM_INPUTS) begin
                cand = cand - C_NUM_INPUTS;
            end
            if (req[IDX_W'(cand)]) begin
                next_idx = GRANT_W'(cand);
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_log_arbiter.sv
// Packet-level round-robin merge of per-collector AXIS log streams into one
// registered output stream; a grant is held from first beat to tlast.
module eth_log_arbiter
    import eth_log_arb_pkg::*;
#(
    parameter int unsigned C_NUM_INPUTS     = 4,
    parameter int unsigned C_AXIS_LOG_WIDTH = 64
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [C_NUM_INPUTS*C_AXIS_LOG_WIDTH-1:0] s_axis_log_tdata,
    input  logic [C_NUM_INPUTS-1:0]                s_axis_log_tlast,
    input  logic [C_NUM_INPUTS-1:0]                s_axis_log_tvalid,
    output logic [C_NUM_INPUTS-1:0]                s_axis_log_tready,
    output logic [C_AXIS_LOG_WIDTH-1:0]            m_axis_log_tdata,
    output logic                                   m_axis_log_tlast,
    output logic                                   m_axis_log_tvalid,
    input  logic                                   m_axis_log_tready,
    input  logic [C_NUM_INPUTS-1:0]                enable_mask,
    output logic [2:0]                             grant_id,
    output logic                                   busy,
    output logic [31:0]                            pkt_count
);

    localparam int unsigned N     = C_NUM_INPUTS;
    localparam int unsigned W     = C_AXIS_LOG_WIDTH;
    localparam int unsigned IDX_W = clog2(C_NUM_INPUTS);

    state_t             state;
    state_t             state_nxt;
    logic [GRANT_W-1:0] last_grant;
    logic [GRANT_W-1:0] pick_idx;
    logic               pick_valid;
    logic [N-1:0]       req;
    logic [IDX_W-1:0]   grant_sel;
    logic               beat_accept;
    logic               beat_last;
    logic [W-1:0]       beat_data;

    assign req       = s_axis_log_tvalid & enable_mask;
    assign grant_sel = IDX_W'(grant_id);

    eth_log_rr_pick #(
        .C_NUM_INPUTS (N)
    ) u_pick (
        .req        (req),
        .last_grant (last_grant),
        .next_idx   (pick_idx),
        .valid      (pick_valid)
    );

    // Granted input's beat; tready is zero in IDLE so an accept implies XFER.
    assign beat_data   = s_axis_log_tdata[int'(grant_sel) * W +: W];
    assign beat_last   = s_axis_log_tlast[grant_sel];
    assign beat_accept = s_axis_log_tvalid[grant_sel] & s_axis_log_tready[grant_sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (pick_valid) state_nxt = ST_XFER;
            ST_XFER: if (beat_accept && beat_last) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Only the granted input sees ready, and only when the output slot can take a beat.
    always_comb begin
        s_axis_log_tready = '0;
        busy              = (state == ST_XFER);
        if (state == ST_XFER) begin
            s_axis_log_tready[grant_sel] = ~m_axis_log_tvalid | m_axis_log_tready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_id          <= '0;
            last_grant        <= GRANT_W'(N - 1);
            m_axis_log_tvalid <= 1'b0;
            m_axis_log_tlast  <= 1'b0;
            m_axis_log_tdata  <= '0;
            pkt_count         <= '0;
        end else begin
            if (state == ST_IDLE && pick_valid) begin
                grant_id <= pick_idx;
            end
            if (beat_accept && beat_last) begin
                last_grant <= grant_id;
            end
            if (beat_accept) begin
                m_axis_log_tdata  <= beat_data;
                m_axis_log_tlast  <= beat_last;
                m_axis_log_tvalid <= 1'b1;
            end else if (m_axis_log_tready) begin
                m_axis_log_tvalid <= 1'b0;
            end
            if (m_axis_log_tvalid && m_axis_log_tready && m_axis_log_tlast) begin
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end

endmodule
